fifo_uart_tx: RTL and testbench
===============================

# fifo_uart_tx

Byte-serialising UART transmitter that drains the 8-bit, 256-deep byte FIFO directly downstream of it. It pops one byte at a time through the FIFO read port (registered output: `q` valid the cycle after `rdreq`) and shifts it out on `txd` as an asynchronous serial frame: start bit, 8 data bits LSB first, optional parity bit, 1 stop bit. It sits between the FIFO and the board serial pin. It is the only reader of that FIFO.

## Interface
- `CLKS_PER_BIT`, 434 — clock cycles per serial bit (50 MHz / 115200); legal range 2..65535.
- `PARITY`, 0 — 0 none, 1 even, 2 odd.
- `clock`  in  1  — single clock; all logic rising-edge.
- `reset`  in  1  — synchronous, active-high.
- `enable`  in  1  — permits starting a new frame; a frame in progress always completes.
- `fifo_q`  in  8  — FIFO read data; valid the cycle after `fifo_rdreq`.
- `fifo_empty`  in  1  — FIFO empty flag.
- `fifo_rdreq`  out  1  — FIFO pop request; one-cycle pulse per byte.
- `txd`  out  1  — serial line; idles high.
- `busy`  out  1  — high in every state except IDLE.
- `frame_done`  out  1  — one-cycle pulse in the last cycle of the stop bit.

## Operation
- States: IDLE, LOAD, START, DATA, PAR, STOP.
- IDLE: `txd`=1.
  - `fifo_rdreq` = `enable && !fifo_empty`; it is combinational in IDLE only and 0 in all other states and during `reset`.
  - When asserted → LOAD.
- LOAD: exactly 1 cycle. Capture `fifo_q` into the 8-bit shift register and compute parity (even: XOR of bits; odd: inverted XOR) → START.
- START: `txd`=0 for `CLKS_PER_BIT` cycles → DATA.
- DATA: `txd` = shift[0] for `CLKS_PER_BIT` cycles per bit; shift right after each bit; after bit index 7 → PAR if `PARITY`≠0, else STOP.
- PAR: `txd`=parity bit for `CLKS_PER_BIT` cycles → STOP.
- STOP: `txd`=1 for `CLKS_PER_BIT` cycles; `frame_done`=1 in its final cycle → IDLE.
- Counters:
  - Bit timer counts 0..`CLKS_PER_BIT`-1; width clog2(`CLKS_PER_BIT`).
  - 3-bit data index counts 0..7; it does not wrap into the next frame.
- `txd` is driven from a register (no combinational glitches on the pin).
- `fifo_empty` is sampled only in IDLE; going empty mid-frame has no effect.
- `enable` deasserted mid-frame: the frame finishes; no further `rdreq` until `enable`=1.
- Simultaneous `reset` and `rdreq` condition: `reset` wins; no pop issued.
- `reset` mid-frame: the next cycle is IDLE, `txd`=1, `busy`=0, counters 0. The partially sent byte is discarded and not re-read.
- Reset values: `txd`=1, `fifo_rdreq`=0, `busy`=0, `frame_done`=0; state IDLE; shift register 0.

## Timing
- `fifo_rdreq` high in cycle c.
  - Byte captured at the edge ending c+1 (LOAD).
  - First start-bit cycle (`txd`=0) is c+2.
- Frame length in cycles: (10 + (`PARITY`≠0)) × `CLKS_PER_BIT`, measured from the first start-bit cycle to the last stop-bit cycle inclusive.
- Back-to-back with the FIFO non-empty:
  - The cycle after `frame_done` is IDLE with `rdreq`=1, then LOAD.
  - Gap between frames: exactly 2 idle-high cycles beyond the stop bit.
  - Throughput: 1 byte per frame + 2 cycles.
- `busy` rises the cycle after `rdreq` (LOAD) and falls the cycle after `frame_done`.
- Only one pop per frame; `fifo_rdreq` is never high on two consecutive cycles.

## Test plan
- Reset: hold `reset` 3 cycles with `fifo_empty`=0, `enable`=1 → `txd`=1, `fifo_rdreq`=0, `busy`=0 throughout. The first `rdreq` occurs the first cycle after `reset` falls.
- Single byte, `CLKS_PER_BIT`=4, `PARITY`=0, FIFO holding 0xA5:
  - `rdreq` pulse in cycle c; `txd`=0 for c+2..c+5.
  - Then bits 1,0,1,0,0,1,0,1 for 4 cycles each, then `txd`=1 for 4 cycles with `frame_done` at c+41.
  - `busy` falls at c+42.
- Parity, `PARITY`=1 then 2, byte 0x07 → parity bit 1 (even) / 0 (odd); frame 44 cycles at `CLKS_PER_BIT`=4.
- Back-to-back: FIFO holding 0x00, 0xFF, 0x3C, `CLKS_PER_BIT`=4:
  - Three `rdreq` pulses spaced 42 cycles apart; line decodes 0x00, 0xFF, 0x3C.
  - `txd` high exactly 6 cycles between consecutive start bits.
- `enable` drop: deassert `enable` during DATA of frame 1 with FIFO non-empty → frame 1 completes, no `rdreq` while `enable`=0. Re-enabling issues `rdreq` the same cycle.
- Mid-frame reset: `reset` pulse 1 cycle in DATA bit 3 → next cycle `txd`=1, `busy`=0. `usedw` not decremented again for the aborted byte. The following frame carries the next FIFO byte.

Source files
------------

// File: rtl/fifo_uart_tx_if.sv
// FIFO read-port bundle between the byte FIFO and the UART transmitter.
// master = the reader (transmitter), slave = the FIFO.
interface fifo_uart_tx_if;
  logic [7:0] fifo_q;
  logic       fifo_empty;
  logic       fifo_rdreq;

  modport master (input fifo_q, input fifo_empty, output fifo_rdreq);
  modport slave  (output fifo_q, output fifo_empty, input fifo_rdreq);
endinterface

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pops bytes from a registered-output FIFO and sends
// start, 8 data bits LSB first, optional parity and one stop bit on txd.
//
// state   | meaning
// S_IDLE  | line high, pop a byte when enabled and FIFO not empty
// S_LOAD  | FIFO data valid, capture byte and parity
// S_START | start bit (txd=0)
// S_DATA  | 8 data bits, LSB first
// S_PAR   | parity bit (only when PARITY != 0)
// S_STOP  | stop bit (txd=1), frame_done in its last cycle
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int PARITY       = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  fifo_uart_tx_if.master        fifo,
  output logic                  txd,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] T_PRE  = TW'(CLKS_PER_BIT - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          par_bit;

  // Pop is decided in the same cycle so the byte is on fifo_q during LOAD.
  always_comb begin
    fifo.fifo_rdreq = (state == S_IDLE) && enable && !fifo.fifo_empty && !reset;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      timer      <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      par_bit    <= 1'b0;
      txd        <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          txd   <= 1'b1;
          timer <= '0;
          if (fifo.fifo_rdreq) begin
            state <= S_LOAD;
            busy  <= 1'b1;
          end
        end

        S_LOAD: begin
          shift   <= fifo.fifo_q;
          par_bit <= (PARITY == 2) ? ~(^fifo.fifo_q) : ^fifo.fifo_q;
          bit_idx <= '0;
          timer   <= '0;
          txd     <= 1'b0;
          state   <= S_START;
        end

        S_START: begin
          if (timer == T_LAST) begin
            timer <= '0;
            txd   <= shift[0];
            state <= S_DATA;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        S_DATA: begin
          if (timer == T_LAST) begin
            timer <= '0;
            shift <= {1'b0, shift[7:1]};
            if (bit_idx == 3'd7) begin
              bit_idx <= '0;
              if (PARITY != 0) begin
                txd   <= par_bit;
                state <= S_PAR;
              end else begin
                txd   <= 1'b1;
                state <= S_STOP;
              end
            end else begin
              bit_idx <= bit_idx + 1'b1;
              txd     <= shift[1];
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end

        S_PAR: begin
          if (timer == T_LAST) begin
            timer <= '0;
            txd   <= 1'b1;
            state <= S_STOP;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        S_STOP: begin
          // frame_done is registered, so it is raised one cycle early.
          if (timer == T_LAST) begin
            timer <= '0;
            busy  <= 1'b0;
            txd   <= 1'b1;
            state <= S_IDLE;
          end else begin
            timer <= timer + 1'b1;
            if (timer == T_PRE) frame_done <= 1'b1;
          end
        end

        default: begin
          state <= S_IDLE;
          txd   <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: three instances (no/even/odd parity, 4 clocks per
// bit), each fed by a small FIFO model with a registered read port.
module tb_fifo_uart_tx;

  localparam int CPB = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b1;

  always #5 clock = ~clock;

  fifo_uart_tx_if if0 ();
  fifo_uart_tx_if if1 ();
  fifo_uart_tx_if if2 ();

  logic [2:0] txd_w, busy_w, fd_w, rdreq_w;
  logic [7:0] q_r [3];
  logic [7:0] mem [3][16];
  int         rd_ptr [3] = '{0, 0, 0};
  int         wr_ptr [3] = '{0, 0, 0};

  assign if0.fifo_q     = q_r[0];
  assign if1.fifo_q     = q_r[1];
  assign if2.fifo_q     = q_r[2];
  assign if0.fifo_empty = (rd_ptr[0] == wr_ptr[0]);
  assign if1.fifo_empty = (rd_ptr[1] == wr_ptr[1]);
  assign if2.fifo_empty = (rd_ptr[2] == wr_ptr[2]);
  assign rdreq_w        = {if2.fifo_rdreq, if1.fifo_rdreq, if0.fifo_rdreq};

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY(0)) dut0 (
    .clock(clock), .reset(reset), .enable(enable), .fifo(if0.master),
    .txd(txd_w[0]), .busy(busy_w[0]), .frame_done(fd_w[0]));
  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY(1)) dut1 (
    .clock(clock), .reset(reset), .enable(enable), .fifo(if1.master),
    .txd(txd_w[1]), .busy(busy_w[1]), .frame_done(fd_w[1]));
  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY(2)) dut2 (
    .clock(clock), .reset(reset), .enable(enable), .fifo(if2.master),
    .txd(txd_w[2]), .busy(busy_w[2]), .frame_done(fd_w[2]));

  always @(posedge clock) begin
    for (int i = 0; i < 3; i++) begin
      if (rdreq_w[i] === 1'b1) begin
        q_r[i]    <= mem[i][rd_ptr[i] % 16];
        rd_ptr[i] <= rd_ptr[i] + 1;
      end
    end
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic push(input int d, input logic [7:0] b);
    mem[d][wr_ptr[d] % 16] = b;
    wr_ptr[d] = wr_ptr[d] + 1;
    #1;
  endtask

  task automatic wait_rdreq(input int d, input int budget, output bit ok, output int waited);
    ok = 1'b0;
    waited = 0;
    for (int i = 0; i < budget; i++) begin
      if (rdreq_w[d] === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
      waited++;
    end
  endtask

  // Returns in the first cycle after the frame (expected IDLE, busy low).
  task automatic check_frame(input int d, input logic [10:0] fr, input int nbits,
                             output int waited);
    bit ok;
    wait_rdreq(d, 200, ok, waited);
    chk("rdreq_seen", {31'd0, ok}, 32'd1);
    if (ok) begin
      tick();
      chk("rdreq_single_pulse", {31'd0, rdreq_w[d]}, 32'd0);
      chk("busy_in_load", {31'd0, busy_w[d]}, 32'd1);
      chk("txd_in_load", {31'd0, txd_w[d]}, 32'd1);
      for (int k = 0; k < nbits; k++) begin
        for (int j = 0; j < CPB; j++) begin
          tick();
          chk("txd_bit", {31'd0, txd_w[d]}, {31'd0, fr[k]});
          chk("busy_frame", {31'd0, busy_w[d]}, 32'd1);
          chk("frame_done", {31'd0, fd_w[d]}, {31'd0, (k == nbits - 1) && (j == CPB - 1)});
        end
      end
      tick();
      chk("busy_after_frame", {31'd0, busy_w[d]}, 32'd0);
      chk("txd_after_frame", {31'd0, txd_w[d]}, 32'd1);
      chk("frame_done_after", {31'd0, fd_w[d]}, 32'd0);
    end
  endtask

  typedef struct {
    int         dut;
    logic [7:0] data;
    logic [10:0] frame;   // bit 0 sent first
    int         nbits;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int  w;
    bit  ok;
    bit  saw_rdreq;
    int  fd_cnt;
    int  p;

    vecs[0] = '{0, 8'h81, {1'b0, 1'b1, 8'h81, 1'b0}, 10};
    vecs[1] = '{1, 8'h07, {1'b1, 1'b1, 8'h07, 1'b0}, 11};
    vecs[2] = '{2, 8'h07, {1'b1, 1'b0, 8'h07, 1'b0}, 11};
    vecs[3] = '{1, 8'h5A, {1'b1, 1'b0, 8'h5A, 1'b0}, 11};
    vecs[4] = '{2, 8'h5A, {1'b1, 1'b1, 8'h5A, 1'b0}, 11};

    // Reset held 3 cycles with data waiting and enable high.
    push(0, 8'hA5);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset_txd", {31'd0, txd_w[0]}, 32'd1);
      chk("reset_rdreq", {31'd0, rdreq_w[0]}, 32'd0);
      chk("reset_busy", {31'd0, busy_w[0]}, 32'd0);
      chk("reset_frame_done", {31'd0, fd_w[0]}, 32'd0);
    end
    reset = 1'b0;
    #1;
    chk("first_rdreq_after_reset", {31'd0, rdreq_w[0]}, 32'd1);
    check_frame(0, {1'b0, 1'b1, 8'hA5, 1'b0}, 10, w);
    chk("a5_wait", w, 32'd0);

    for (int v = 0; v < 5; v++) begin
      push(vecs[v].dut, vecs[v].data);
      check_frame(vecs[v].dut, vecs[v].frame, vecs[v].nbits, w);
      tick();
    end

    // Back-to-back frames: next pop in the cycle right after each frame.
    push(0, 8'h00);
    push(0, 8'hFF);
    push(0, 8'h3C);
    check_frame(0, {1'b0, 1'b1, 8'h00, 1'b0}, 10, w);
    check_frame(0, {1'b0, 1'b1, 8'hFF, 1'b0}, 10, w);
    chk("b2b_gap_2", w, 32'd0);
    check_frame(0, {1'b0, 1'b1, 8'h3C, 1'b0}, 10, w);
    chk("b2b_gap_3", w, 32'd0);
    chk("b2b_fifo_drained", {31'd0, if0.fifo_empty}, 32'd1);

    // Enable dropped mid-frame with FIFO still holding a byte.
    tick();
    push(0, 8'h11);
    push(0, 8'h22);
    wait_rdreq(0, 20, ok, w);
    chk("en_first_rdreq", {31'd0, ok}, 32'd1);
    for (int i = 0; i < 10; i++) tick();
    enable = 1'b0;
    saw_rdreq = 1'b0;
    fd_cnt = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (rdreq_w[0] !== 1'b0) saw_rdreq = 1'b1;
      if (fd_w[0] === 1'b1) fd_cnt++;
    end
    chk("en_drop_no_rdreq", {31'd0, saw_rdreq}, 32'd0);
    chk("en_drop_frame_done", fd_cnt, 32'd1);
    chk("en_drop_idle_busy", {31'd0, busy_w[0]}, 32'd0);
    enable = 1'b1;
    #1;
    chk("reenable_rdreq", {31'd0, rdreq_w[0]}, 32'd1);
    check_frame(0, {1'b0, 1'b1, 8'h22, 1'b0}, 10, w);
    chk("reenable_wait", w, 32'd0);

    // Reset pulse during data bit 3; the aborted byte is not fetched again.
    tick();
    push(0, 8'h33);
    push(0, 8'h44);
    wait_rdreq(0, 20, ok, w);
    chk("mid_reset_rdreq", {31'd0, ok}, 32'd1);
    for (int i = 0; i < 19; i++) tick();
    chk("mid_reset_in_data", {31'd0, busy_w[0]}, 32'd1);
    p = rd_ptr[0];
    reset = 1'b1;
    tick();
    chk("mid_reset_txd", {31'd0, txd_w[0]}, 32'd1);
    chk("mid_reset_busy", {31'd0, busy_w[0]}, 32'd0);
    chk("mid_reset_no_pop", {31'd0, rdreq_w[0]}, 32'd0);
    chk("mid_reset_ptr", rd_ptr[0], p);
    reset = 1'b0;
    #1;
    check_frame(0, {1'b0, 1'b1, 8'h44, 1'b0}, 10, w);
    chk("mid_reset_next_wait", w, 32'd0);

    tick();
    chk("total_pops_dut0", rd_ptr[0], 32'd9);
    chk("total_pops_dut1", rd_ptr[1], 32'd2);
    chk("total_pops_dut2", rd_ptr[2], 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

endmodule
